collision_sweep: RTL and testbench

COLLISION_SWEEP -- requirements
Module: collision_sweep

---
 rtl/collision_pkg.sv | 38 +++
 rtl/aabb_collision.sv | 14 +
 rtl/collision_sweep.sv | 151 +++++++++++++++
 tb/tb_collision_sweep.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared types and elaboration helpers for the collision sweep engine.
// POSITION_WIDTH sets the coordinate width; it defaults to 16 bits when not defined.
`ifndef POSITION_WIDTH
`define POSITION_WIDTH 16
`endif

package collision_pkg;

  localparam int PW = `POSITION_WIDTH;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SWEEP = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;

  typedef struct packed {
    logic [PW-1:0] x1;
    logic [PW-1:0] y1;
    logic [PW-1:0] x2;
    logic [PW-1:0] y2;
  } box_t;

  // Number of unordered pairs (a,b), a<b, among n slots.
  function automatic int pair_count(input int n);
    return (n * (n - 1)) / 2;
  endfunction

  // Bits needed to hold values 0..n-1 (at least one bit).
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/aabb_collision.sv
// Axis-aligned bounding-box overlap test between two boxes (x1,y1) .. (x2,y2).
module aabb_collision
  import collision_pkg::*;
(
  input  box_t i_a,
  input  box_t i_b,
  output logic o_overlap
);

  // Strict inequalities: boxes that only share an edge or a corner do not overlap.
  assign o_overlap = (i_a.x1 < i_b.x2) && (i_b.x1 < i_a.x2) &&
                     (i_a.y1 < i_b.y2) && (i_b.y1 < i_a.y2);

endmodule

// File: rtl/collision_sweep.sv
// Brute-force pairwise collision sweep over a small register table of boxes.
// Define COLLISION_PAIR_STREAM_EN to add the pair_* hit stream with back-pressure.
module collision_sweep
  import collision_pkg::*;
#(
  parameter int NUM_OBJ = 8,
  parameter int IDX_W   = 3
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [PW-1:0]      wr_x1,
  input  logic [PW-1:0]      wr_y1,
  input  logic [PW-1:0]      wr_x2,
  input  logic [PW-1:0]      wr_y2,
  input  logic               wr_active,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [NUM_OBJ-1:0] hit_mask
`ifdef COLLISION_PAIR_STREAM_EN
  ,
  output logic               pair_valid,
  input  logic               pair_ready,
  output logic [IDX_W-1:0]   pair_a,
  output logic [IDX_W-1:0]   pair_b
`endif
);

  localparam int PAIRS = pair_count(NUM_OBJ);
  localparam int CNT_W = idx_width(PAIRS);

  box_t               r_box [NUM_OBJ];
  logic [NUM_OBJ-1:0] r_active;
  state_t             r_state;
  logic [IDX_W-1:0]   r_a;
  logic [IDX_W-1:0]   r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_OBJ-1:0] r_hit_mask;

  logic w_stall;
  logic w_drained;
  logic w_issue;
  logic w_last;
  logic w_overlap;
  logic w_hit;

  assign busy     = (r_state != ST_IDLE);
  assign hit_mask = r_hit_mask;
  assign w_issue  = (r_state == ST_SWEEP) && !w_stall;
  assign w_last   = (r_cnt == CNT_W'(PAIRS - 1));
  assign w_hit    = w_issue && w_overlap && r_active[r_a] && r_active[r_b];
  assign done     = (r_state == ST_FLUSH) && w_drained;

  // NOTE: the table is reset entry by entry because a cleared table is part of the
  // defined reset state; this forces flops rather than a RAM macro, which is fine at this size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OBJ; i++) r_box[i] <= '0;
      r_active <= '0;
    end else if (wr_en && (r_state == ST_IDLE)) begin
      r_box[wr_idx]    <= '{x1: wr_x1, y1: wr_y1, x2: wr_x2, y2: wr_y2};
      r_active[wr_idx] <= wr_active;
    end
  end

  aabb_collision u_cmp (
    .i_a       (r_box[r_a]),
    .i_b       (r_box[r_b]),
    .o_overlap (w_overlap)
  );

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_a        <= '0;
      r_b        <= IDX_W'(1);
      r_cnt      <= '0;
      r_hit_mask <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_SWEEP;
            r_a        <= '0;
            r_b        <= IDX_W'(1);
            r_cnt      <= '0;
            r_hit_mask <= '0;
          end
        end
        ST_SWEEP: begin
          if (w_issue) begin
            if (w_hit) begin
              r_hit_mask <= r_hit_mask | (NUM_OBJ'(1) << r_a) | (NUM_OBJ'(1) << r_b);
            end
            r_cnt <= r_cnt + CNT_W'(1);
            // Row-major walk of the upper triangle: b wraps to a+2 when a advances.
            if (r_b == IDX_W'(NUM_OBJ - 1)) begin
              r_a <= r_a + IDX_W'(1);
              r_b <= r_a + IDX_W'(2);
            end else begin
              r_b <= r_b + IDX_W'(1);
            end
            if (w_last) r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_drained) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef COLLISION_PAIR_STREAM_EN
  logic             r_pv;
  logic [IDX_W-1:0] r_pa;
  logic [IDX_W-1:0] r_pb;

  // A held word stalls issue, so a new hit can only load the buffer when it is
  // empty or transferring in the same cycle; nothing is dropped or repeated.
  assign w_stall   = r_pv && !pair_ready;
  assign w_drained = !r_pv || pair_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv <= 1'b0;
      r_pa <= '0;
      r_pb <= '0;
    end else if (w_hit) begin
      r_pv <= 1'b1;
      r_pa <= r_a;
      r_pb <= r_b;
    end else if (pair_ready) begin
      r_pv <= 1'b0;
    end
  end

  assign pair_valid = r_pv;
  assign pair_a     = r_pa;
  assign pair_b     = r_pb;
`else
  assign w_stall   = 1'b0;
  assign w_drained = 1'b1;
`endif

endmodule

// File: tb/tb_collision_sweep.sv
// Self-checking bench for collision_sweep against a pairwise box-overlap model.
`timescale 1ns/1ps
`ifndef POSITION_WIDTH
`define POSITION_WIDTH 16
`endif

module tb_collision_sweep;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int W  = `POSITION_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_idx = '0;
  logic [W-1:0]  wr_x1 = '0, wr_y1 = '0, wr_x2 = '0, wr_y2 = '0;
  logic          wr_active = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [N-1:0]  hit_mask;
`ifdef COLLISION_PAIR_STREAM_EN
  logic          pair_valid;
  logic          pair_ready = 1'b1;
  logic [IW-1:0] pair_a, pair_b;
`endif

  int checks = 0;
  int errors = 0;

  int m_x1 [N];
  int m_y1 [N];
  int m_x2 [N];
  int m_y2 [N];
  bit m_act [N];
  int exp_pairs [$];
  int got_pairs [$];

  always #5 clk = ~clk;

  collision_sweep #(.NUM_OBJ(N), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_x1      (wr_x1),
    .wr_y1      (wr_y1),
    .wr_x2      (wr_x2),
    .wr_y2      (wr_y2),
    .wr_active  (wr_active),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .hit_mask   (hit_mask)
`ifdef COLLISION_PAIR_STREAM_EN
    ,
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .pair_a     (pair_a),
    .pair_b     (pair_b)
`endif
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit m_overlap(input int i, input int j);
    return (m_x1[i] < m_x2[j]) && (m_x1[j] < m_x2[i]) &&
           (m_y1[i] < m_y2[j]) && (m_y1[j] < m_y2[i]);
  endfunction

  task automatic model_sweep(output logic [N-1:0] mask);
    mask = '0;
    exp_pairs.delete();
    for (int a = 0; a < N - 1; a++) begin
      for (int b = a + 1; b < N; b++) begin
        if (m_act[a] && m_act[b] && m_overlap(a, b)) begin
          mask[a] = 1'b1;
          mask[b] = 1'b1;
          exp_pairs.push_back(a * 16 + b);
        end
      end
    end
  endtask

  task automatic set_model(input int idx, input int x1, input int y1, input int x2,
                           input int y2, input bit act);
    m_x1[idx] = x1; m_y1[idx] = y1; m_x2[idx] = x2; m_y2[idx] = y2; m_act[idx] = act;
  endtask

  task automatic drive_wr(input int idx, input int x1, input int y1, input int x2,
                          input int y2, input bit act);
    wr_en = 1'b1; wr_idx = IW'(idx);
    wr_x1 = W'(x1); wr_y1 = W'(y1); wr_x2 = W'(x2); wr_y2 = W'(y2);
    wr_active = act;
  endtask

  task automatic write_slot(input int idx, input int x1, input int y1, input int x2,
                            input int y2, input bit act);
    drive_wr(idx, x1, y1, x2, y2, act);
    set_model(idx, x1, y1, x2, y2, act);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  function automatic int far_x(input int i);
    return 200 + i * 50;
  endfunction

  task automatic set_far();
    for (int i = 0; i < N; i++) write_slot(i, far_x(i), 200, far_x(i) + 20, 220, 1'b1);
  endtask

  // Start a sweep, follow it to done, compare against the model.
  // ready_mode: 0 always ready, 1 random ready, 2 ready low in cycles 10..19.
  // exp_lat <= 0 skips the exact latency comparison. inject drives a write and a
  // second start in cycle 5 that the busy DUT must ignore.
  task automatic run_sweep(input string name, input int ready_mode, input int exp_lat,
                           input bit inject);
    logic [N-1:0] exp_mask;
    int lat;
    bit seen;
    model_sweep(exp_mask);
    got_pairs.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    lat = 1;
    seen = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
    end
    while (!seen && lat < 500) begin
`ifdef COLLISION_PAIR_STREAM_EN
      case (ready_mode)
        1:       pair_ready = 1'($urandom_range(0, 1));
        2:       pair_ready = !(lat >= 10 && lat < 20);
        default: pair_ready = 1'b1;
      endcase
`endif
      if (inject && lat == 5) begin
        drive_wr(1, far_x(7), 200, far_x(7) + 20, 220, 1'b1);
        start = 1'b1;
      end else if (inject && lat == 6) begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      #1;
`ifdef COLLISION_PAIR_STREAM_EN
      if (pair_valid === 1'b1 && pair_ready === 1'b1)
        got_pairs.push_back(int'(pair_a) * 16 + int'(pair_b));
`endif
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: no done after %0d cycles", name, lat);
    end
    if (exp_lat > 0) begin
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
      end
    end
    checks++;
    if (hit_mask !== exp_mask) begin
      errors++;
      $display("FAIL %s hit_mask: got %h expected %h", name, hit_mask, exp_mask);
    end
`ifdef COLLISION_PAIR_STREAM_EN
    checks++;
    if (got_pairs.size() != exp_pairs.size()) begin
      errors++;
      $display("FAIL %s pair_count: got %0d expected %0d", name, got_pairs.size(),
               exp_pairs.size());
    end else begin
      for (int i = 0; i < exp_pairs.size(); i++) begin
        if (got_pairs[i] != exp_pairs[i]) begin
          errors++;
          $display("FAIL %s pair_%0d: got (%0d,%0d) expected (%0d,%0d)", name, i,
                   got_pairs[i] / 16, got_pairs[i] % 16, exp_pairs[i] / 16,
                   exp_pairs[i] % 16);
          break;
        end
      end
    end
`endif
    @(negedge clk);
`ifdef COLLISION_PAIR_STREAM_EN
    pair_ready = 1'b1;
    checks++;
    if (pair_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s pair_valid_after_done: got %b expected 0", name, pair_valid);
    end
`endif
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || hit_mask !== exp_mask) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b mask=%h expected 0 0 %h", name,
               done, busy, hit_mask, exp_mask);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hit_mask !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b mask=%h expected 0 0 00", busy,
               done, hit_mask);
    end
`ifdef COLLISION_PAIR_STREAM_EN
    checks++;
    if (pair_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_pair_valid: got %b expected 0", pair_valid);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) set_model(i, 0, 0, 0, 0, 1'b0);
    run_sweep("reset_empty_table", 0, 29, 1'b0);
  endtask

  task automatic test_basic();
    set_far();
    write_slot(0, 0, 0, 10, 10, 1'b1);
    write_slot(3, 5, 5, 15, 15, 1'b1);
    run_sweep("basic_0_3", 0, 29, 1'b0);
  endtask

  task automatic test_touch();
    set_far();
    write_slot(1, 0, 0, 10, 10, 1'b1);
    write_slot(2, 10, 0, 20, 10, 1'b1);
    run_sweep("touching_edges", 0, 29, 1'b0);
  endtask

  task automatic test_all_same();
    for (int i = 0; i < N; i++) write_slot(i, 3, 4, 30, 40, 1'b1);
    run_sweep("all_identical", 0, 29, 1'b0);
  endtask

  task automatic test_inactive();
    set_far();
    write_slot(4, 0, 0, 10, 10, 1'b1);
    write_slot(5, 5, 5, 15, 15, 1'b0);
    run_sweep("inactive_slot5", 0, 29, 1'b0);
  endtask

`ifdef COLLISION_PAIR_STREAM_EN
  task automatic test_stall();
    for (int i = 0; i < N; i++) write_slot(i, 3, 4, 30, 40, 1'b1);
    run_sweep("ready_low_10", 2, 39, 1'b0);
  endtask
`endif

  task automatic test_busy_write();
    set_far();
    run_sweep("write_while_busy", 0, 29, 1'b1);
    run_sweep("write_while_busy_recheck", 0, 29, 1'b0);
  endtask

  task automatic test_start_with_write();
    set_far();
    drive_wr(2, far_x(6) + 5, 205, far_x(6) + 15, 215, 1'b1);
    set_model(2, far_x(6) + 5, 205, far_x(6) + 15, 215, 1'b1);
    run_sweep("start_with_write", 0, 29, 1'b0);
  endtask

  task automatic test_reset_abort();
    set_far();
    write_slot(0, 0, 0, 10, 10, 1'b1);
    write_slot(3, 5, 5, 15, 15, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    checks++;
    if (hit_mask !== 8'h09 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_before_reset: got mask=%h busy=%b expected 09 1", hit_mask, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hit_mask !== '0) begin
      errors++;
      $display("FAIL abort_immediate: got busy=%b done=%b mask=%h expected 0 0 00", busy,
               done, hit_mask);
    end
`ifdef COLLISION_PAIR_STREAM_EN
    checks++;
    if (pair_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_pair_valid: got %b expected 0", pair_valid);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_held_%0d: got done=%b busy=%b expected 0 0", i, done, busy);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_model(i, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    run_sweep("after_abort_cleared", 0, 29, 1'b0);
    set_far();
    write_slot(0, 0, 0, 10, 10, 1'b1);
    write_slot(3, 5, 5, 15, 15, 1'b1);
    run_sweep("after_abort_basic", 0, 29, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int mode;
      for (int i = 0; i < N; i++) begin
        int x, y;
        x = $urandom_range(0, 40);
        y = $urandom_range(0, 40);
        write_slot(i, x, y, x + $urandom_range(1, 15), y + $urandom_range(1, 15),
                   ($urandom_range(0, 3) != 0));
      end
      mode = $urandom_range(0, 1);
`ifdef COLLISION_PAIR_STREAM_EN
      run_sweep($sformatf("random_%0d", it), mode, (mode == 0) ? 29 : 0, 1'b0);
`else
      run_sweep($sformatf("random_%0d_m%0d", it, mode), 0, 29, 1'b0);
`endif
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_touch();
    test_all_same();
    test_inactive();
`ifdef COLLISION_PAIR_STREAM_EN
    test_stall();
`endif
    test_busy_write();
    test_start_with_write();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
